hub75_buf_ctrl: RTL and testbench
=================================

// Module: hub75_buf_ctrl
// PURPOSE
//  Double-buffer controller for the HUB75 frame buffer (2 banks x frame_size_p pixels).
//  - Routes host pixel writes into the back bank; the display path reads only the front bank.
//  - On host commit, swaps banks only at a display frame boundary, so the panel never shows a torn frame.
//  - Optionally clears the back bank to black in hardware.
//  - Sits between the host write interface and the frame-buffer RAM write port.
//  - Takes frame boundaries from hub75_control.
// PARAMETERS
//  hpixel_p    64  display width in pixels
//  vpixel_p    64  display height in pixels
//  bpp_p       8   bits per colour channel
//  segments_p  2   display segments (passed through; does not affect this block's logic)
//  (local) frame_size_p = hpixel_p*vpixel_p; addr_width_p = $clog2(frame_size_p)
// PORTS
//  clk              in   1               system clock
//  rst_n            in   1               asynchronous active-low reset
//  i_wr_addr        in   addr_width_p    host pixel address
//  i_wr_data        in   3*bpp_p         host pixel {R,G,B}
//  i_wr_en          in   1               host write strobe
//  i_commit         in   1               pulse: back bank complete, request swap
//  i_clear          in   1               pulse: fill back bank with zero
//  o_wr_ready       out  1               1 = host writes/commit/clear accepted
//  o_wr_err         out  1               sticky: write dropped (not ready or addr out of range)
//  i_disp_active    in   1               display scanning (hub75 enable)
//  i_frame_done     in   1               pulse from hub75_control after last row/last bit plane
//  o_rd_bank        out  1               front bank select to display read path
//  o_swap_done      out  1               1-cycle pulse on bank swap
//  o_ram_wr_addr    out  addr_width_p+1  {bank, pixel addr} to frame-buffer RAM
//  o_ram_wr_data    out  3*bpp_p         RAM write data
//  o_ram_wr_en      out  1               RAM write enable
// BEHAVIOUR
//  Reset (async, any state)
//   - State ST_WRITE; o_rd_bank=0, so the back bank is 1.
//   - All other outputs 0, except o_wr_ready=1.
//   - commit_pend=0; clear counter=0.
//   - An in-progress clear or pending swap is abandoned.
//  Back-bank bit is always ~o_rd_bank.
//  o_wr_ready = (state==ST_WRITE), driven from registered state.
//  ST_WRITE
//   - Accepted write (i_wr_en & i_wr_addr<frame_size_p): on the next edge, o_ram_wr_en=1 and
//     o_ram_wr_addr={~o_rd_bank,i_wr_addr}, data registered. Latency 1 cycle.
//   - Write that is not accepted (out of range, or not ready): dropped, o_wr_err<=1.
//   - i_clear: go to ST_CLEAR. If i_commit is also high, set commit_pend=1.
//   - i_commit alone: go to ST_SWAP_PEND.
//   - A write in the same cycle as commit or clear is still performed.
//  ST_CLEAR
//   - Counter runs 0..frame_size_p-1, one write per cycle.
//   - RAM port: data=0, addr={~o_rd_bank,cnt}, en=1; exactly frame_size_p cycles.
//   - i_commit during ST_CLEAR is ignored.
//   - After the last address: commit_pend ? ST_SWAP_PEND : ST_WRITE; clear commit_pend.
//  ST_SWAP_PEND
//   - Swap on (i_frame_done | ~i_disp_active).
//   - Swap edge: o_rd_bank toggles, o_swap_done=1 for one cycle, return to ST_WRITE.
//   - An i_frame_done in the same cycle as commit is not used; the swap waits for the next boundary.
//  o_wr_err clears only on reset.
// STRUCTURE
//  hub75_pkg: buf_state_t enum {ST_WRITE,ST_CLEAR,ST_SWAP_PEND}; frame-size/addr-width functions.
//  No sub-module: one FSM, one clear counter, registered RAM-port stage.
// TESTING
//  1 Reset -> o_rd_bank=0, o_wr_ready=1, o_ram_wr_en=0, o_wr_err=0.
//  2 Write addr 5, data 24'hFF0000 -> next cycle o_ram_wr_en=1, o_ram_wr_addr={1'b1,12'd5}, data FF0000.
//  3 Commit, i_disp_active=1, i_frame_done 100 cycles later:
//     - o_wr_ready=0 for 100 cycles; then o_rd_bank=1 and o_swap_done pulses.
//     - Next write goes to bank 0.
//  4 Clear -> 4096 consecutive zero writes, addr {1,0}..{1,4095}; o_wr_ready low exactly 4096 cycles.
//  5 Clear+commit same cycle -> full clear, then ST_SWAP_PEND; swap on the following i_frame_done only.
//  6 Writes during swap-pending drop with o_wr_err=1; rst_n low mid-clear -> reset values at once, no further RAM writes.

Source files
------------

// File: rtl/hub75_buf_ctrl_pkg.sv
// Shared types and sizing helpers for the HUB75 double-buffer controller.
package hub75_buf_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_WRITE     = 2'd0,
        ST_CLEAR     = 2'd1,
        ST_SWAP_PEND = 2'd2
    } buf_state_t;

    function automatic int frame_size_f(input int h, input int v);
        return h * v;
    endfunction

    function automatic int addr_width_f(input int h, input int v);
        return (h * v > 1) ? $clog2(h * v) : 1;
    endfunction

endpackage

// File: rtl/hub75_buf_ctrl_if.sv
// Host-side pixel write / commit / clear bus of the HUB75 frame buffer.
interface hub75_buf_ctrl_if #(
    parameter int addr_width_p = 12,
    parameter int data_width_p = 24
);
    logic [addr_width_p-1:0] i_wr_addr;
    logic [data_width_p-1:0] i_wr_data;
    logic                    i_wr_en;
    logic                    i_commit;
    logic                    i_clear;
    logic                    o_wr_ready;
    logic                    o_wr_err;

    modport master (
        output i_wr_addr, i_wr_data, i_wr_en, i_commit, i_clear,
        input  o_wr_ready, o_wr_err
    );

    modport slave (
        input  i_wr_addr, i_wr_data, i_wr_en, i_commit, i_clear,
        output o_wr_ready, o_wr_err
    );
endinterface

// File: rtl/hub75_buf_ctrl.sv
// Double-buffer controller: host writes land in the back bank, bank swap
// happens only at a display frame boundary, optional hardware clear.
//
// state        | meaning
// ST_WRITE     | host writes accepted into back bank
// ST_CLEAR     | filling back bank with zero, one pixel per cycle
// ST_SWAP_PEND | back bank committed, waiting for frame boundary to swap
module hub75_buf_ctrl
    import hub75_buf_ctrl_pkg::*;
#(
    parameter int hpixel_p   = 64,
    parameter int vpixel_p   = 64,
    parameter int bpp_p      = 8,
    parameter int segments_p = 2,
    localparam int frame_size_p = frame_size_f(hpixel_p, vpixel_p),
    localparam int addr_width_p = addr_width_f(hpixel_p, vpixel_p)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hub75_buf_ctrl_if.slave         host,
    input  logic                    i_disp_active,
    input  logic                    i_frame_done,
    output logic                    o_rd_bank,
    output logic                    o_swap_done,
    output logic [addr_width_p:0]   o_ram_wr_addr,
    output logic [3*bpp_p-1:0]      o_ram_wr_data,
    output logic                    o_ram_wr_en
);

    localparam logic [addr_width_p:0]   frame_lim = (addr_width_p+1)'(frame_size_p);
    localparam logic [addr_width_p-1:0] cnt_last  = addr_width_p'(frame_size_p - 1);

    if (segments_p < 1) begin : g_bad_segments
        $error("hub75_buf_ctrl: segments_p must be at least 1");
    end

    buf_state_t              state;
    logic                    commit_pend;
    logic                    wr_err;
    logic [addr_width_p-1:0] clr_cnt;
    logic                    addr_ok;

    assign addr_ok         = ({1'b0, host.i_wr_addr} < frame_lim);
    assign host.o_wr_ready = (state == ST_WRITE);
    assign host.o_wr_err   = wr_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_WRITE;
            commit_pend   <= 1'b0;
            wr_err        <= 1'b0;
            clr_cnt       <= '0;
            o_rd_bank     <= 1'b0;
            o_swap_done   <= 1'b0;
            o_ram_wr_addr <= '0;
            o_ram_wr_data <= '0;
            o_ram_wr_en   <= 1'b0;
        end else begin
            o_ram_wr_en <= 1'b0;
            o_swap_done <= 1'b0;

            case (state)
                ST_WRITE: begin
                    if (host.i_wr_en) begin
                        if (addr_ok) begin
                            o_ram_wr_en   <= 1'b1;
                            o_ram_wr_addr <= {~o_rd_bank, host.i_wr_addr};
                            o_ram_wr_data <= host.i_wr_data;
                        end else begin
                            wr_err <= 1'b1;
                        end
                    end
                    if (host.i_clear) begin
                        state       <= ST_CLEAR;
                        clr_cnt     <= '0;
                        commit_pend <= host.i_commit;
                    end else if (host.i_commit) begin
                        state <= ST_SWAP_PEND;
                    end
                end

                ST_CLEAR: begin
                    if (host.i_wr_en) wr_err <= 1'b1;
                    o_ram_wr_en   <= 1'b1;
                    o_ram_wr_addr <= {~o_rd_bank, clr_cnt};
                    o_ram_wr_data <= '0;
                    if (clr_cnt == cnt_last) begin
                        clr_cnt     <= '0;
                        commit_pend <= 1'b0;
                        state       <= commit_pend ? ST_SWAP_PEND : ST_WRITE;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end

                ST_SWAP_PEND: begin
                    if (host.i_wr_en) wr_err <= 1'b1;
                    // An idle display has no boundary to wait for, so swap at once.
                    if (i_frame_done || !i_disp_active) begin
                        o_rd_bank   <= ~o_rd_bank;
                        o_swap_done <= 1'b1;
                        state       <= ST_WRITE;
                    end
                end

                default: state <= ST_WRITE;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_buf_ctrl.sv
// Directed self-checking bench for hub75_buf_ctrl (64x64, 8 bpp).
module tb_hub75_buf_ctrl;

    localparam int AW = 12;
    localparam int DW = 24;
    localparam int FS = 4096;

    logic          clk;
    logic          rst_n;
    logic          disp_active;
    logic          frame_done;
    logic          rd_bank;
    logic          swap_done;
    logic [AW:0]   ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic          ram_wr_en;

    int tests = 0;
    int fails = 0;

    hub75_buf_ctrl_if #(.addr_width_p(AW), .data_width_p(DW)) host_if ();

    hub75_buf_ctrl #(
        .hpixel_p(64), .vpixel_p(64), .bpp_p(8), .segments_p(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .host          (host_if.slave),
        .i_disp_active (disp_active),
        .i_frame_done  (frame_done),
        .o_rd_bank     (rd_bank),
        .o_swap_done   (swap_done),
        .o_ram_wr_addr (ram_wr_addr),
        .o_ram_wr_data (ram_wr_data),
        .o_ram_wr_en   (ram_wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int low_cnt;
        int bad_cnt;

        rst_n              = 1'b1;
        disp_active        = 1'b0;
        frame_done         = 1'b0;
        host_if.i_wr_addr  = '0;
        host_if.i_wr_data  = '0;
        host_if.i_wr_en    = 1'b0;
        host_if.i_commit   = 1'b0;
        host_if.i_clear    = 1'b0;
        #3 rst_n = 1'b0;
        tick(); tick();

        // Reset values
        chk("rst_rd_bank",   32'(rd_bank), 32'd0);
        chk("rst_wr_ready",  32'(host_if.o_wr_ready), 32'd1);
        chk("rst_ram_wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst_wr_err",    32'(host_if.o_wr_err), 32'd0);
        chk("rst_swap_done", 32'(swap_done), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single write, one-cycle latency, back bank 1
        host_if.i_wr_en   = 1'b1;
        host_if.i_wr_addr = 12'd5;
        host_if.i_wr_data = 24'hFF0000;
        tick();
        host_if.i_wr_en = 1'b0;
        chk("wr_en",   32'(ram_wr_en), 32'd1);
        chk("wr_addr", 32'(ram_wr_addr), 32'h1005);
        chk("wr_data", 32'(ram_wr_data), 32'hFF0000);
        tick();
        chk("wr_en_off", 32'(ram_wr_en), 32'd0);

        // Hardware clear of bank 1
        host_if.i_clear = 1'b1;
        tick();
        host_if.i_clear = 1'b0;
        low_cnt = 0;
        bad_cnt = 0;
        if (!host_if.o_wr_ready) low_cnt++;
        for (int k = 0; k < FS; k++) begin
            tick();
            if (!(ram_wr_en === 1'b1 && ram_wr_addr === {1'b1, 12'(k)} && ram_wr_data === 24'h0))
                bad_cnt++;
            if (!host_if.o_wr_ready) low_cnt++;
        end
        chk("clr_bad_writes", 32'(bad_cnt), 32'd0);
        chk("clr_ready_low",  32'(low_cnt), 32'(FS));
        tick();
        chk("clr_end_en", 32'(ram_wr_en), 32'd0);

        // Commit while displaying; swap on frame_done 100 cycles later
        disp_active      = 1'b1;
        host_if.i_commit = 1'b1;
        tick();
        host_if.i_commit = 1'b0;
        low_cnt = 0;
        if (!host_if.o_wr_ready) low_cnt++;
        for (int k = 0; k < 99; k++) begin
            tick();
            if (!host_if.o_wr_ready) low_cnt++;
        end
        chk("pend_ready_low", 32'(low_cnt), 32'd100);
        chk("pend_rd_bank",   32'(rd_bank), 32'd0);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        chk("swap_rd_bank",  32'(rd_bank), 32'd1);
        chk("swap_done",     32'(swap_done), 32'd1);
        chk("swap_ready",    32'(host_if.o_wr_ready), 32'd1);
        host_if.i_wr_en   = 1'b1;
        host_if.i_wr_addr = 12'd7;
        host_if.i_wr_data = 24'h00FF00;
        tick();
        host_if.i_wr_en = 1'b0;
        chk("swap_done_pulse", 32'(swap_done), 32'd0);
        chk("bank0_wr_en",     32'(ram_wr_en), 32'd1);
        chk("bank0_wr_addr",   32'(ram_wr_addr), 32'h0007);
        chk("bank0_wr_data",   32'(ram_wr_data), 32'h00FF00);

        // Clear+commit together, frame_done in that cycle and mid-clear is ignored
        host_if.i_clear  = 1'b1;
        host_if.i_commit = 1'b1;
        frame_done       = 1'b1;
        tick();
        host_if.i_clear  = 1'b0;
        host_if.i_commit = 1'b0;
        bad_cnt = 0;
        for (int k = 0; k < FS; k++) begin
            frame_done = (k == 100);
            host_if.i_commit = (k == 200);
            tick();
            if (!(ram_wr_en === 1'b1 && ram_wr_addr === {1'b0, 12'(k)} && ram_wr_data === 24'h0))
                bad_cnt++;
        end
        frame_done       = 1'b0;
        host_if.i_commit = 1'b0;
        chk("cc_bad_writes", 32'(bad_cnt), 32'd0);
        chk("cc_rd_bank",    32'(rd_bank), 32'd1);
        chk("cc_ready",      32'(host_if.o_wr_ready), 32'd0);
        repeat (5) tick();
        chk("cc_wait_bank",  32'(rd_bank), 32'd1);
        chk("cc_wait_ready", 32'(host_if.o_wr_ready), 32'd0);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        chk("cc_swap_bank", 32'(rd_bank), 32'd0);
        chk("cc_swap_done", 32'(swap_done), 32'd1);

        // Write dropped while swap pending
        chk("err_before", 32'(host_if.o_wr_err), 32'd0);
        host_if.i_commit = 1'b1;
        tick();
        host_if.i_commit  = 1'b0;
        host_if.i_wr_en   = 1'b1;
        host_if.i_wr_addr = 12'd9;
        host_if.i_wr_data = 24'h0000FF;
        tick();
        host_if.i_wr_en = 1'b0;
        chk("drop_wr_en", 32'(ram_wr_en), 32'd0);
        chk("drop_err",   32'(host_if.o_wr_err), 32'd1);
        disp_active = 1'b0;
        tick();
        chk("idle_swap_bank", 32'(rd_bank), 32'd1);
        chk("idle_swap_done", 32'(swap_done), 32'd1);
        chk("err_sticky",     32'(host_if.o_wr_err), 32'd1);
        disp_active = 1'b1;

        // Async reset in the middle of a clear
        host_if.i_clear = 1'b1;
        tick();
        host_if.i_clear = 1'b0;
        repeat (10) tick();
        chk("midclr_en", 32'(ram_wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en",  32'(ram_wr_en), 32'd0);
        chk("arst_ready",  32'(host_if.o_wr_ready), 32'd1);
        chk("arst_bank",   32'(rd_bank), 32'd0);
        chk("arst_err",    32'(host_if.o_wr_err), 32'd0);
        chk("arst_addr",   32'(ram_wr_addr), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        bad_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (ram_wr_en !== 1'b0) bad_cnt++;
        end
        chk("post_rst_no_wr", 32'(bad_cnt), 32'd0);
        chk("post_rst_ready", 32'(host_if.o_wr_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
